adc4_selftrig: RTL and testbench

//  Per-channel self-trigger stage directly downstream of the 4-channel ADC receiver.
//  - Input: 48-bit word, 4 channels x 12-bit unsigned samples.
//  - Per channel: tracks the baseline, subtracts it, discriminates against a threshold

---
 rtl/adc4_selftrig.sv | 181 ++++++++++++++++++
 tb/tb_adc4_selftrig.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/adc4_selftrig.sv
// Four-channel self-trigger: per-channel baseline tracking, threshold discriminator
// with hold-off and hit counters, plus raw data re-aligned to the trigger.

module adc4_selftrig_ch #(
  parameter int BLSHIFT = 4,
  parameter int HOLDOFF = 16,
  parameter int CNT_W   = 16
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             s1_vld,
  input  logic             s2_vld,
  input  logic [11:0]      s1,
  input  logic             enb,
  input  logic             inv,
  input  logic [11:0]      thr,
  input  logic             cnt_enb,
  input  logic             cnt_reset,
  output logic             trig_nxt,
  output logic             trig,
  output logic             above,
  output logic [CNT_W-1:0] hit_cnt
);
  typedef enum logic [1:0] {IDLE, ABOVE, HOLD} state_t;
  localparam int AW = 12 + BLSHIFT;
  localparam int HW = $clog2(HOLDOFF + 1);

  state_t              state, nxt;
  logic [AW-1:0]       acc;
  logic                init;
  logic [11:0]         bl, bl_eff;
  logic signed [12:0]  diff, amp;
  logic                hit;
  logic [HW-1:0]       hcnt, hcnt_nxt;

  // While the init flag is up the baseline is the sample itself, so the
  // very first sample can never look like a pulse.
  assign bl     = acc[AW-1:BLSHIFT];
  assign bl_eff = init ? s1 : bl;
  assign diff   = $signed({1'b0, s1}) - $signed({1'b0, bl_eff});
  assign hit    = s2_vld && enb && (amp > $signed({1'b0, thr}));

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      acc  <= '0;
      init <= 1'b1;
      amp  <= '0;
    end else begin
      amp <= inv ? -diff : diff;
      if (s1_vld) begin
        if (init) begin
          acc  <= {s1, {BLSHIFT{1'b0}}};
          init <= 1'b0;
        end else if (state == IDLE && enb) begin
          acc <= acc + AW'(s1) - AW'(bl);
        end
      end
    end
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      state <= IDLE;
      hcnt  <= '0;
      trig  <= 1'b0;
    end else begin
      state <= nxt;
      hcnt  <= hcnt_nxt;
      trig  <= trig_nxt;
    end
  end

  always_comb begin
    nxt      = state;
    hcnt_nxt = hcnt;
    if (!enb) begin
      nxt      = IDLE;
      hcnt_nxt = '0;
    end else begin
      case (state)
        IDLE:  if (hit) nxt = ABOVE;
        ABOVE: if (!hit) begin
                 nxt      = HOLD;
                 hcnt_nxt = HW'(HOLDOFF);
               end
        // hits here are ignored on purpose; the count only runs down
        HOLD:  begin
                 hcnt_nxt = hcnt - HW'(1);
                 if (hcnt == HW'(1)) nxt = IDLE;
               end
        default: nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    trig_nxt = (state == IDLE) && (nxt == ABOVE);
    above    = (state == ABOVE);
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)                                   hit_cnt <= '0;
    else if (cnt_reset)                            hit_cnt <= '0;
    else if (cnt_enb && trig && (hit_cnt != '1))   hit_cnt <= hit_cnt + CNT_W'(1);
  end
endmodule

module adc4_selftrig #(
  parameter int BLSHIFT = 4,
  parameter int HOLDOFF = 16,
  parameter int CNT_W   = 16   // hit counter width, at most 16
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic [47:0] DIN,
  input  logic [3:0]  ch_enb,
  input  logic [3:0]  ch_inv,
  input  logic [11:0] thr,
  input  logic [3:0]  trig_mask,
  input  logic        cnt_reset,
  input  logic        cnt_enb,
  input  logic [1:0]  cnt_sel,
  output logic [47:0] DOUT,
  output logic        TRIG,
  output logic [3:0]  ch_trig,
  output logic [3:0]  ch_above,
  output logic [15:0] cnt_out
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 12;
  localparam int STAGES    = 1;

  logic [NUM_LANES-1:0][VEC_W-1:0] s1, d2, d3;
  logic [STAGES:0]                 vld_pipe;
  logic [NUM_LANES-1:0]            trig_nxt;
  logic [NUM_LANES-1:0][CNT_W-1:0] hit_cnt;

  // s1 doubles as the first DOUT delay stage
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      s1       <= '0;
      d2       <= '0;
      d3       <= '0;
      vld_pipe <= '0;
      TRIG     <= 1'b0;
      cnt_out  <= '0;
    end else begin
      s1       <= DIN;
      d2       <= s1;
      d3       <= d2;
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
      TRIG     <= |(trig_nxt & trig_mask);
      cnt_out  <= 16'(hit_cnt[cnt_sel]);
    end
  end

  assign DOUT = d3;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_ch
    adc4_selftrig_ch #(
      .BLSHIFT(BLSHIFT),
      .HOLDOFF(HOLDOFF),
      .CNT_W  (CNT_W)
    ) u_ch (
      .gclk     (CLK),
      .grst_n   (reset_n),
      .s1_vld   (vld_pipe[0]),
      .s2_vld   (vld_pipe[1]),
      .s1       (s1[k]),
      .enb      (ch_enb[k]),
      .inv      (ch_inv[k]),
      .thr      (thr),
      .cnt_enb  (cnt_enb),
      .cnt_reset(cnt_reset),
      .trig_nxt (trig_nxt[k]),
      .trig     (ch_trig[k]),
      .above    (ch_above[k]),
      .hit_cnt  (hit_cnt[k])
    );
  end
endmodule

// File: tb/tb_adc4_selftrig.sv
// Directed bench for adc4_selftrig; a second instance with 2-bit counters
// shares all inputs so saturation is reachable in a short run.

module tb_adc4_selftrig;
  logic        CLK = 1'b0;
  logic        reset_n;
  logic [47:0] DIN;
  logic [3:0]  ch_enb, ch_inv, trig_mask;
  logic [11:0] thr;
  logic        cnt_reset, cnt_enb;
  logic [1:0]  cnt_sel;
  logic [47:0] DOUT, s_DOUT;
  logic        TRIG, s_TRIG;
  logic [3:0]  ch_trig, ch_above, s_ch_trig, s_ch_above;
  logic [15:0] cnt_out, s_cnt_out;

  int n_tests = 0, n_fail = 0;
  int tc[4], ac[4], tp, dout_err = 0, nv = 0;
  logic [47:0] h0, h1, h2;

  always #5 CLK = ~CLK;

  adc4_selftrig #(.BLSHIFT(4), .HOLDOFF(16)) dut (
    .CLK(CLK), .reset_n(reset_n), .DIN(DIN), .ch_enb(ch_enb), .ch_inv(ch_inv),
    .thr(thr), .trig_mask(trig_mask), .cnt_reset(cnt_reset), .cnt_enb(cnt_enb),
    .cnt_sel(cnt_sel), .DOUT(DOUT), .TRIG(TRIG), .ch_trig(ch_trig),
    .ch_above(ch_above), .cnt_out(cnt_out)
  );

  adc4_selftrig #(.BLSHIFT(4), .HOLDOFF(16), .CNT_W(2)) dut_sat (
    .CLK(CLK), .reset_n(reset_n), .DIN(DIN), .ch_enb(ch_enb), .ch_inv(ch_inv),
    .thr(thr), .trig_mask(trig_mask), .cnt_reset(cnt_reset), .cnt_enb(cnt_enb),
    .cnt_sel(cnt_sel), .DOUT(s_DOUT), .TRIG(s_TRIG), .ch_trig(s_ch_trig),
    .ch_above(s_ch_above), .cnt_out(s_cnt_out)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // channels in m get v, the rest sit at the 2000 baseline
  task automatic drive(input logic [3:0] m, input logic [11:0] v);
    for (int k = 0; k < 4; k++) DIN[12*k +: 12] = m[k] ? v : 12'd2000;
  endtask

  task automatic tick();
    @(posedge CLK);
    if (reset_n) begin h2 = h1; h1 = h0; h0 = DIN; nv++; end
    else nv = 0;
    @(negedge CLK);
    if (nv >= 3 && (DOUT !== h2 || s_DOUT !== h2)) dout_err++;
    for (int k = 0; k < 4; k++) begin
      tc[k] += int'(ch_trig[k]);
      ac[k] += int'(ch_above[k]);
    end
    tp += int'(TRIG);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clr();
    for (int k = 0; k < 4; k++) begin tc[k] = 0; ac[k] = 0; end
    tp = 0;
  endtask

  function automatic int tsum();
    return tc[0] + tc[1] + tc[2] + tc[3];
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    reset_n = 1'b0; drive(4'h0, 12'd0);
    ch_enb = 4'hF; ch_inv = 4'h0; thr = 12'd50; trig_mask = 4'hF;
    cnt_reset = 1'b0; cnt_enb = 1'b1; cnt_sel = 2'd0;
    clr();
    run(2);
    chk("rst_dout", DOUT, 0);
    chk("rst_trig", TRIG, 0);
    chk("rst_chtrig", ch_trig, 0);
    chk("rst_above", ch_above, 0);
    chk("rst_cnt", cnt_out, 0);

    // flat input: no triggers, DOUT is DIN delayed
    reset_n = 1'b1; clr(); run(40);
    chk("t1_hits", tsum(), 0);
    chk("t1_TRIG", tp, 0);
    chk("t1_dout", dout_err, 0);

    // single positive step on ch0
    clr(); drive(4'b0001, 12'd2100); run(2);
    chk("t2_early", ch_trig, 0);
    run(1);
    chk("t2_chtrig", ch_trig, 4'b0001);
    chk("t2_TRIG", TRIG, 1);
    run(2); drive(4'h0, 12'd0); run(80);
    chk("t2_hits0", tc[0], 1);
    chk("t2_hits_oth", tc[1] + tc[2] + tc[3], 0);
    chk("t2_npulse", tp, 1);
    chk("t2_above", ac[0], 5);
    chk("t2_cnt", cnt_out, 1);

    // negative dip on ch1, with and without inversion
    clr(); ch_inv = 4'b0010; drive(4'b0010, 12'd1900); run(5); drive(4'h0, 12'd0); run(80);
    chk("t3_inv_hit", tc[1], 1);
    chk("t3_inv_TRIG", tp, 1);
    clr(); ch_inv = 4'b0000; drive(4'b0010, 12'd1900); run(5); drive(4'h0, 12'd0); run(80);
    chk("t3_noinv", tsum(), 0);

    // hold-off on ch2: second pulse 5 cycles after -> ignored
    cnt_sel = 2'd2;
    clr(); drive(4'b0100, 12'd2100); run(5); drive(4'h0, 12'd0); run(5);
    drive(4'b0100, 12'd2100); run(3); drive(4'h0, 12'd0); run(80);
    chk("t4_short_hits", tc[2], 1);
    chk("t4_short_above", ac[2], 5);
    cnt_reset = 1'b1; run(1); cnt_reset = 1'b0; run(1);
    chk("t4_clr", cnt_out, 0);
    // second pulse 20 cycles after -> counted
    clr(); drive(4'b0100, 12'd2100); run(5); drive(4'h0, 12'd0); run(20);
    drive(4'b0100, 12'd2100); run(3); drive(4'h0, 12'd0); run(80);
    chk("t4_long_hits", tc[2], 2);
    chk("t4_cnt", cnt_out, 2);
    cnt_sel = 2'd0;
    chk("sel_lat", cnt_out, 2);
    run(1);
    chk("sel_new", cnt_out, 0);

    // coincident ch0/ch3 steps with masking
    trig_mask = 4'b1000;
    clr(); drive(4'b1001, 12'd2100); run(3);
    chk("t5_chtrig", ch_trig, 4'b1001);
    chk("t5_TRIG", TRIG, 1);
    run(2); drive(4'h0, 12'd0); run(80);
    chk("t5_npulse", tp, 1);
    trig_mask = 4'b0000;
    clr(); drive(4'b1001, 12'd2100); run(5); drive(4'h0, 12'd0); run(80);
    chk("t5_nomask", tp, 0);
    chk("t5_hits", tc[0] + tc[3], 2);

    // saturation: ch0 now at 2, two more hits -> 4 wide, 3 (all ones) narrow
    chk("t6_pre", cnt_out, 2);
    repeat (2) begin
      drive(4'b0001, 12'd2100); run(5); drive(4'h0, 12'd0); run(80);
    end
    chk("t6_cnt4", cnt_out, 4);
    chk("t6_sat", s_cnt_out, 3);

    // cnt_reset in the same cycle as an increment
    drive(4'b0001, 12'd2100);
    w = 0;
    while (ch_trig[0] !== 1'b1 && w < 6) begin run(1); w++; end
    chk("t6_trig_seen", ch_trig[0], 1);
    cnt_reset = 1'b1; run(1); cnt_reset = 1'b0; run(2);
    chk("t6_clr_hit", cnt_out, 0);
    chk("t6_sat_clr", s_cnt_out, 0);
    drive(4'h0, 12'd0); run(80);

    // async reset while ch0 is above threshold
    drive(4'b0001, 12'd2100); run(5);
    chk("t6_above_pre", ch_above[0], 1);
    chk("t6_cnt_pre", cnt_out, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_rst_dout", DOUT, 0);
    chk("t6_rst_trig", TRIG, 0);
    chk("t6_rst_chtrig", ch_trig, 0);
    chk("t6_rst_above", ch_above, 0);
    chk("t6_rst_cnt", cnt_out, 0);
    drive(4'h0, 12'd0); run(2);
    reset_n = 1'b1; clr(); run(40);
    chk("t6_reinit", tsum(), 0);
    clr(); drive(4'b0010, 12'd2100); run(3);
    chk("t6_post", ch_trig, 4'b0010);
    drive(4'h0, 12'd0); run(30);
    chk("dout_all", dout_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
